if_fetch_ctrl: RTL and testbench

//  Sequencer for the IF stage: drives the IF control inputs LRCR, mux1CR and PCCR each cycle.

---
 rtl/if_fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencer: arbitrates branch/call/return redirects, inserts flush bubbles, applies stall/halt.
// Latency: control outputs are combinational from state and inputs, so IF acts on the same clock edge.
// Backpressure: stall holds the PC and withholds redirect acks; requesters keep their level until redir_ack.
module if_fetch_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             br_req,
    input  logic             call_req,
    input  logic             ret_req,
    input  logic             halt_req,
    output logic             LRCR,
    output logic [1:0]       mux1CR,
    output logic             PCCR,
    output logic             redir_ack,
    output logic             if_valid,
    output logic             flush,
    output logic             busy,
    output logic             lr_valid,
    output logic             err,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // PC source select encodings seen by IF
    localparam logic [1:0] PC_HOLD = 2'd0;
    localparam logic [1:0] PC_INC  = 2'd1;
    localparam logic [1:0] PC_TGT  = 2'd2;
    localparam logic [1:0] PC_LR   = 2'd3;

    // Bubble counter is loaded with one less than the bubble count; zero means last bubble.
    localparam logic [2:0]       FL_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] fl_cnt;
    logic [2:0] fl_cnt_nxt;
    logic       lr_valid_nxt;
    logic       err_nxt;

    // State, bubble counter, link-register tracking and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            fl_cnt   <= 3'd0;
            lr_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            fl_cnt   <= fl_cnt_nxt;
            lr_valid <= lr_valid_nxt;
            err      <= err_nxt;
        end
    end

    // Per-cycle decision: next state and the IF control word
    always_comb begin
        state_nxt    = state;
        fl_cnt_nxt   = fl_cnt;
        lr_valid_nxt = lr_valid;
        err_nxt      = err;
        LRCR         = 1'b0;
        mux1CR       = PC_HOLD;
        PCCR         = 1'b0;
        redir_ack    = 1'b0;
        if_valid     = 1'b0;
        flush        = 1'b0;

        case (state)
            S_IDLE, S_HALT: begin
                // Resuming from HALT leaves the PC where it stopped.
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                if (halt_req) begin
                    state_nxt = S_HALT;
                end else if (stall) begin
                    // Hold PC; pending redirects stay un-acked and are retried.
                end else if (ret_req && lr_valid) begin
                    mux1CR       = PC_LR;
                    PCCR         = 1'b1;
                    redir_ack    = 1'b1;
                    flush        = 1'b1;
                    lr_valid_nxt = 1'b0;
                    fl_cnt_nxt   = FL_LOAD;
                    state_nxt    = S_FLUSH;
                end else begin
                    // A return with no live LR is an error but does not block a call/branch.
                    if (ret_req) begin
                        err_nxt = 1'b1;
                    end
                    if (call_req) begin
                        mux1CR       = PC_TGT;
                        PCCR         = 1'b1;
                        LRCR         = 1'b1;
                        redir_ack    = 1'b1;
                        flush        = 1'b1;
                        lr_valid_nxt = 1'b1;
                        fl_cnt_nxt   = FL_LOAD;
                        state_nxt    = S_FLUSH;
                    end else if (br_req) begin
                        mux1CR     = PC_TGT;
                        PCCR       = 1'b1;
                        redir_ack  = 1'b1;
                        flush      = 1'b1;
                        fl_cnt_nxt = FL_LOAD;
                        state_nxt  = S_FLUSH;
                    end else begin
                        mux1CR   = PC_INC;
                        PCCR     = 1'b1;
                        if_valid = 1'b1;
                    end
                end
            end

            S_FLUSH: begin
                // Requests, including halt, wait until the first FETCH cycle.
                flush = 1'b1;
                if (fl_cnt == 3'd0) begin
                    state_nxt = S_FETCH;
                end else begin
                    fl_cnt_nxt = fl_cnt - 3'd1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Busy while sequencing instructions or bubbles
    always_comb begin
        busy = (state == S_FETCH) || (state == S_FLUSH);
    end

    // Saturating count of valid fetches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
        end else if (if_valid && (fetch_cnt != CNT_MAX)) begin
            fetch_cnt <= fetch_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: two instances (default, and 3 bubbles with a 4-bit counter) share stimulus.
// Each is compared every cycle against a behavioural model of running/bubbles/LR/error/count.
module tb_if_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic br_req = 1'b0;
    logic call_req = 1'b0;
    logic ret_req = 1'b0;
    logic halt_req = 1'b0;

    logic       lrcr_o [2];
    logic [1:0] mux_o  [2];
    logic       pccr_o [2];
    logic       ack_o  [2];
    logic       ifv_o  [2];
    logic       flush_o[2];
    logic       busy_o [2];
    logic       lrv_o  [2];
    logic       err_o  [2];
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .br_req(br_req),
        .call_req(call_req), .ret_req(ret_req), .halt_req(halt_req),
        .LRCR(lrcr_o[0]), .mux1CR(mux_o[0]), .PCCR(pccr_o[0]), .redir_ack(ack_o[0]),
        .if_valid(ifv_o[0]), .flush(flush_o[0]), .busy(busy_o[0]), .lr_valid(lrv_o[0]),
        .err(err_o[0]), .fetch_cnt(cnt0)
    );

    if_fetch_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .br_req(br_req),
        .call_req(call_req), .ret_req(ret_req), .halt_req(halt_req),
        .LRCR(lrcr_o[1]), .mux1CR(mux_o[1]), .PCCR(pccr_o[1]), .redir_ack(ack_o[1]),
        .if_valid(ifv_o[1]), .flush(flush_o[1]), .busy(busy_o[1]), .lr_valid(lrv_o[1]),
        .err(err_o[1]), .fetch_cnt(cnt1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: is the sequencer running, bubbles still owed, LR live, error, fetch count.
    int fc[2]   = '{1, 3};
    int cmax[2] = '{65535, 15};
    bit m_act[2];
    int m_bub[2];
    bit m_lr[2];
    bit m_err[2];
    int m_cnt[2];

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            m_bub[i] = 0;
            m_lr[i]  = 1'b0;
            m_err[i] = 1'b0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic check_inst(input int i);
        string pre = (i == 0) ? "d0" : "d1";
        int e_lrcr = 0;
        int e_mux = 0;
        int e_pccr = 0;
        int e_ack = 0;
        int e_ifv = 0;
        int e_flush = 0;
        int e_busy = 0;
        logic [31:0] obs_cnt;
        if (m_act[i]) begin
            e_busy = 1;
            if (m_bub[i] > 0) begin
                e_flush = 1;
            end else if (halt_req || stall) begin
                e_busy = 1;
            end else if (ret_req && m_lr[i]) begin
                e_mux = 3; e_pccr = 1; e_ack = 1; e_flush = 1;
            end else if (call_req) begin
                e_mux = 2; e_pccr = 1; e_ack = 1; e_flush = 1; e_lrcr = 1;
            end else if (br_req) begin
                e_mux = 2; e_pccr = 1; e_ack = 1; e_flush = 1;
            end else begin
                e_mux = 1; e_pccr = 1; e_ifv = 1;
            end
        end
        obs_cnt = (i == 0) ? 32'(cnt0) : 32'(cnt1);
        chk({pre, "_LRCR"},      32'(lrcr_o[i]),  e_lrcr);
        chk({pre, "_mux1CR"},    32'(mux_o[i]),   e_mux);
        chk({pre, "_PCCR"},      32'(pccr_o[i]),  e_pccr);
        chk({pre, "_redir_ack"}, 32'(ack_o[i]),   e_ack);
        chk({pre, "_if_valid"},  32'(ifv_o[i]),   e_ifv);
        chk({pre, "_flush"},     32'(flush_o[i]), e_flush);
        chk({pre, "_busy"},      32'(busy_o[i]),  e_busy);
        chk({pre, "_lr_valid"},  32'(lrv_o[i]),   int'(m_lr[i]));
        chk({pre, "_err"},       32'(err_o[i]),   int'(m_err[i]));
        chk({pre, "_fetch_cnt"}, obs_cnt,         m_cnt[i]);
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_act[i]) begin
                    if (start) m_act[i] = 1'b1;
                end else if (m_bub[i] > 0) begin
                    m_bub[i]--;
                end else if (halt_req) begin
                    m_act[i] = 1'b0;
                end else if (!stall) begin
                    if (ret_req && !m_lr[i]) m_err[i] = 1'b1;
                    if (ret_req && m_lr[i]) begin
                        m_lr[i]  = 1'b0;
                        m_bub[i] = fc[i];
                    end else if (call_req) begin
                        m_lr[i]  = 1'b1;
                        m_bub[i] = fc[i];
                    end else if (br_req) begin
                        m_bub[i] = fc[i];
                    end else if (m_cnt[i] < cmax[i]) begin
                        m_cnt[i]++;
                    end
                end
            end
        end
    endtask

    // One cycle: apply inputs just after the falling edge, check, then cross the rising edge.
    task automatic step(input bit s, input bit st, input bit br, input bit ca, input bit re, input bit ha);
        start    = s;
        stall    = st;
        br_req   = br;
        call_req = ca;
        ret_req  = re;
        halt_req = ha;
        #1;
        check_inst(0);
        check_inst(1);
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        // Reset state, with start ignored while reset is held
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // T1: start then ten sequential fetches
        step(1, 0, 0, 0, 0, 0);
        idle_steps(10);
        chk("t1_fetch_cnt", 32'(cnt0), 10);

        // T2: branch, bubble, resume
        step(0, 0, 1, 0, 0, 0);
        idle_steps(4);

        // T3: call, return, then a return with no live LR
        step(0, 0, 0, 1, 0, 0);
        idle_steps(4);
        step(0, 0, 0, 0, 1, 0);
        idle_steps(4);
        step(0, 0, 0, 0, 1, 0);
        chk("t3_err", 32'(err_o[0]), 1);
        idle_steps(2);

        // T4: stalled branch held for three cycles, then acked
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle_steps(4);

        // T5: halt, idle in HALT, resume
        step(0, 0, 0, 0, 0, 1);
        idle_steps(2);
        step(1, 0, 0, 0, 0, 0);
        idle_steps(5);

        // Random mix of requests, including simultaneous call+ret and halt during bubbles
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(99) < 30, $urandom_range(99) < 20, $urandom_range(99) < 15,
                 $urandom_range(99) < 12, $urandom_range(99) < 15, $urandom_range(99) < 5);
        end

        // Saturation of the 4-bit counter
        step(1, 0, 0, 0, 0, 0);
        idle_steps(20);
        chk("sat_cnt4", 32'(cnt1), 15);

        // T6: reset asserted while dut0 is flushing
        step(0, 0, 1, 0, 0, 0);
        chk("t6_in_flush", 32'(flush_o[0]), 1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("t6_flush_async", 32'(flush_o[0]), 0);
        chk("t6_cnt_async", 32'(cnt0), 0);
        check_inst(0);
        check_inst(1);
        @(posedge clk);
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        idle_steps(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
